// File: rtl/ecc_sed_pkg.sv
// ecc_sed_pkg: widths and the parity helper shared by the SED encoder and checker.
//   SED_DATA_W  data bits per codeword
//   SED_CW_W    codeword width (data + one even-parity bit)
//   SED_PAR_BIT bit position of the parity bit inside the codeword
//   sed_parity  XOR reduction; 0 for a codeword with even parity
package ecc_sed_pkg;

    localparam int unsigned SED_DATA_W  = 12;
    localparam int unsigned SED_CW_W    = SED_DATA_W + 1;
    localparam int unsigned SED_PAR_BIT = SED_DATA_W;

    function automatic logic sed_parity(input logic [SED_CW_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ecc_sed_checker_if.sv
// ecc_sed_checker_if: encoder-to-checker and checker-to-sink signals.
//   enc_valid, enc_codeword  codeword stream from the encoder (no backpressure)
//   dec_valid, dec_ready     show-ahead handshake toward the sink
//   dec_data, dec_err        head word with parity stripped, and its check result
//   modport slave  : the checker side
//   modport master : the encoder/sink side
interface ecc_sed_checker_if
    import ecc_sed_pkg::*;
#(
    parameter int unsigned DATA_W = SED_DATA_W
) ();

    logic              enc_valid;
    logic [DATA_W:0]   enc_codeword;
    logic              dec_valid;
    logic              dec_ready;
    logic [DATA_W-1:0] dec_data;
    logic              dec_err;

    modport slave (
        input  enc_valid,
        input  enc_codeword,
        input  dec_ready,
        output dec_valid,
        output dec_data,
        output dec_err
    );

    modport master (
        output enc_valid,
        output enc_codeword,
        output dec_ready,
        input  dec_valid,
        input  dec_data,
        input  dec_err
    );

endinterface

// File: rtl/ecc_sed_fifo.sv
// ecc_sed_fifo: synchronous show-ahead FIFO; rdata always shows the head entry.
//   clk, rst     clock and synchronous active-high reset
//   push, wdata  write request and data (ignored when full unless popping)
//   pop          remove head (ignored when empty)
//   rdata        head entry, valid while empty=0
//   full, empty  occupancy flags
module ecc_sed_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A push at full is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage: no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ecc_sed_checker.sv
// ecc_sed_checker: parity check of SED codewords, buffered toward a stalling sink.
//   clk, rst     clock and synchronous active-high reset
//   bus          ecc_sed_checker_if slave: encoder stream in, show-ahead words out
//   clr_counts   clears err_count, drop_count and overflow (wins over increments)
//   err_count    saturating count of words failing the parity check
//   drop_count   saturating count of words lost because the FIFO was full
//   overflow     sticky flag, set on the first dropped word
module ecc_sed_checker
    import ecc_sed_pkg::*;
#(
    parameter int unsigned DATA_W = SED_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    ecc_sed_checker_if.slave bus,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);

    localparam int unsigned    FIFO_W  = DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;
    logic              push;
    logic              pop;
    logic              drop;
    logic              err_hit;
    logic              full;
    logic              empty;
    logic [FIFO_W-1:0] rdata;

    // Stage 1: register the codeword and its parity check result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= bus.enc_valid;
            s1_data  <= bus.enc_codeword[DATA_W-1:0];
            s1_err   <= sed_parity(SED_CW_W'(bus.enc_codeword));
        end
    end

    assign pop     = ~empty & bus.dec_ready;
    assign push    = s1_valid & (~full | pop);
    assign drop    = s1_valid & full & ~pop;
    assign err_hit = s1_valid & s1_err;

    ecc_sed_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({s1_err, s1_data}),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign bus.dec_valid = ~empty;
    assign bus.dec_data  = rdata[DATA_W-1:0];
    assign bus.dec_err   = rdata[DATA_W];

    // Saturating error/drop counters and sticky overflow; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            err_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (err_hit && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (drop && (drop_count != CNT_MAX)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_sed_checker.sv
// tb_ecc_sed_checker: directed scenarios plus random traffic against a queue-based model.
module tb_ecc_sed_checker;
    import ecc_sed_pkg::*;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_counts;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;

    ecc_sed_checker_if #(.DATA_W(DATA_W)) bus ();

    ecc_sed_checker #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_counts (clr_counts),
        .err_count  (err_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        bit [11:0]   data;
    } word_t;

    word_t     q[$];
    bit        m_s1_v;
    bit [11:0] m_s1_d;
    bit        m_s1_e;
    int        m_err;
    int        m_drop;
    bit        m_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: one register stage, then a bounded queue; counters by rule.
    task automatic model_edge(input bit v, input bit [12:0] cw, input bit rdy,
                              input bit clr, input bit r);
        bit    pop_now;
        bit    push_now;
        bit    drop_now;
        word_t w;
        if (r) begin
            q.delete();
            m_s1_v = 1'b0;
            m_err  = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
            return;
        end
        pop_now  = (q.size() != 0) && rdy;
        push_now = m_s1_v && ((q.size() < DEPTH) || pop_now);
        drop_now = m_s1_v && !push_now;
        w.err    = m_s1_e;
        w.data   = m_s1_d;
        if (pop_now)  void'(q.pop_front());
        if (push_now) q.push_back(w);
        if (clr) begin
            m_err  = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            if (m_s1_v && m_s1_e && m_err < CMAX) m_err++;
            if (drop_now && m_drop < CMAX) m_drop++;
            if (drop_now) m_ovf = 1'b1;
        end
        m_s1_v = v;
        m_s1_d = cw[11:0];
        m_s1_e = ($countones(cw) % 2) == 1;
    endtask

    task automatic compare_all();
        chk("dec_valid", 32'(bus.dec_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("dec_data", 32'(bus.dec_data), 32'(q[0].data));
            chk("dec_err",  32'(bus.dec_err),  32'(q[0].err));
        end
        chk("err_count",  32'(err_count),  32'(m_err));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare after it.
    task automatic step(input bit v, input bit [12:0] cw, input bit rdy,
                        input bit clr, input bit r);
        bus.enc_valid    = v;
        bus.enc_codeword = cw;
        bus.dec_ready    = rdy;
        clr_counts       = clr;
        rst              = r;
        @(posedge clk);
        model_edge(v, cw, rdy, clr, r);
        #1;
        compare_all();
    endtask

    task automatic put(input bit [12:0] cw, input bit rdy);
        step(1'b1, cw, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 13'(($urandom)), rdy, 1'b0, 1'b0);
    endtask

    task automatic clear();
        step(1'b0, 13'h0, 1'b1, 1'b1, 1'b0);
    endtask

    // 12'hABC has seven set bits, so its clean codeword carries parity 1.
    localparam logic [12:0] CW_GOOD = 13'h1ABC;
    localparam logic [12:0] CW_BAD1 = 13'h0ABC;
    localparam logic [12:0] CW_BAD2 = 13'h1ABF;

    initial begin
        bus.enc_valid    = 1'b0;
        bus.enc_codeword = '0;
        bus.dec_ready    = 1'b1;
        clr_counts       = 1'b0;
        rst              = 1'b1;

        // Reset state
        step(1'b0, 13'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 13'h0, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);

        // Clean word: visible two cycles after presentation
        put(CW_GOOD, 1'b1);
        chk("lat_edge1", 32'(bus.dec_valid), 32'd0);
        idle(1'b1);
        chk("clean_valid", 32'(bus.dec_valid), 32'd1);
        chk("clean_data", 32'(bus.dec_data), 32'hABC);
        chk("clean_err", 32'(bus.dec_err), 32'd0);
        idle(1'b1);

        // Single flip detected, double flip escapes
        put(CW_BAD1, 1'b1);
        put(CW_BAD2, 1'b1);
        chk("flip1_err", 32'(bus.dec_err), 32'd1);
        chk("flip1_data", 32'(bus.dec_data), 32'hABC);
        chk("flip1_cnt", 32'(err_count), 32'd1);
        idle(1'b1);
        chk("flip2_err", 32'(bus.dec_err), 32'd0);
        idle(1'b1);
        clear();

        // Backpressure: four held, fifth dropped, then drain in order
        for (int i = 0; i < 5; i++) put(13'({1'b0, 12'(i + 1)}) ^ 13'h1000, 1'b0);
        idle(1'b0);
        chk("bp_drop", 32'(drop_count), 32'd1);
        chk("bp_ovf", 32'(overflow), 32'd1);
        chk("bp_head", 32'(bus.dec_data), 32'd1);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("bp_empty", 32'(bus.dec_valid), 32'd0);
        clear();

        // Full FIFO with a pop and a push in the same cycle
        for (int i = 0; i < 5; i++) put(13'($urandom), 1'b0);
        idle(1'b1);
        chk("fullpop_drop", 32'(drop_count), 32'd0);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("fullpop_empty", 32'(bus.dec_valid), 32'd0);

        // Saturation, then clear beating a same-cycle increment
        clear();
        for (int i = 0; i < 5; i++) put(CW_BAD1, 1'b1);
        idle(1'b1);
        chk("sat_err", 32'(err_count), 32'd3);
        put(CW_BAD1, 1'b1);
        step(1'b0, 13'h0, 1'b1, 1'b1, 1'b0);
        chk("clr_err", 32'(err_count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        idle(1'b1);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) put(CW_BAD1, 1'b0);
        idle(1'b0);
        step(1'b0, 13'h0, 1'b0, 1'b0, 1'b1);
        chk("mrst_valid", 32'(bus.dec_valid), 32'd0);
        chk("mrst_err", 32'(err_count), 32'd0);
        put(CW_GOOD, 1'b1);
        idle(1'b1);
        chk("mrst_word", 32'(bus.dec_data), 32'hABC);
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 13'($urandom),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
